// File: rtl/mem_access.sv
// Memory-access pipeline stage: serialises byte/half/word loads and stores onto a
// byte-wide RAM port, stalling the pipeline until the access completes.
module mem_access #(
  parameter logic [7:0] OP_LB  = 8'h20,
  parameter logic [7:0] OP_LH  = 8'h21,
  parameter logic [7:0] OP_LW  = 8'h22,
  parameter logic [7:0] OP_LBU = 8'h23,
  parameter logic [7:0] OP_LHU = 8'h24,
  parameter logic [7:0] OP_SB  = 8'h25,
  parameter logic [7:0] OP_SH  = 8'h26,
  parameter logic [7:0] OP_SW  = 8'h27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  input  logic        wreg_i,
  output logic [4:0]  rd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic [31:0] ram_addr_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  k_r;
  logic [7:0]  op_r;
  logic [31:0] base_r;
  logic [31:0] sdata_r;
  logic [4:0]  rd_r;
  logic        wreg_r;
  logic [31:0] asm_r;
  logic [2:0]  n_s;
  logic [31:0] addr_k_s;
  logic [7:0]  store_byte_s;

  function automatic logic is_load_f(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store_f(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [2:0] n_bytes_f(input logic [7:0] op);
    logic [2:0] n;
    case (op)
      OP_LB, OP_LBU, OP_SB: n = 3'd1;
      OP_LH, OP_LHU, OP_SH: n = 3'd2;
      default:              n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend_f(input logic [7:0] op, input logic [31:0] a);
    logic [31:0] r;
    case (op)
      OP_LB:   r = {{24{a[7]}}, a[7:0]};
      OP_LH:   r = {{16{a[15]}}, a[15:0]};
      OP_LBU:  r = {24'd0, a[7:0]};
      OP_LHU:  r = {16'd0, a[15:0]};
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] byte_sel_f(input logic [31:0] d, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return b;
  endfunction

  assign n_s          = n_bytes_f(op_r);
  assign addr_k_s     = base_r + {29'd0, k_r};
  assign store_byte_s = byte_sel_f(sdata_r, k_r[1:0]);

  // Next-state and output decode; reset forces every output quiet in the same cycle.
  always_comb begin
    state_s     = state_r;
    stall_req_o = 1'b0;
    ram_wr_o    = 1'b0;
    ram_addr_o  = 32'd0;
    ram_dout_o  = 8'd0;
    rd_o        = 5'd0;
    wreg_o      = 1'b0;
    wdata_o     = 32'd0;
    if (rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (is_load_f(aluop_i) || is_store_f(aluop_i)) begin
            stall_req_o = 1'b1;
            state_s     = ACCESS;
          end else begin
            rd_o    = rd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        ACCESS: begin
          stall_req_o = 1'b1;
          if (is_store_f(op_r)) begin
            ram_wr_o   = 1'b1;
            ram_addr_o = addr_k_s;
            ram_dout_o = store_byte_s;
            state_s    = (k_r == n_s - 3'd1) ? DONE : ACCESS;
          end else begin
            // Loads run one extra cycle to collect the last byte's registered read data.
            ram_addr_o = (k_r < n_s) ? addr_k_s : 32'd0;
            state_s    = (k_r == n_s) ? DONE : ACCESS;
          end
        end
        DONE: begin
          state_s = IDLE;
          if (is_load_f(op_r)) begin
            rd_o    = rd_r;
            wreg_o  = wreg_r;
            wdata_o = extend_f(op_r, asm_r);
          end else begin
            rd_o    = 5'd0;
            wreg_o  = 1'b0;
            wdata_o = 32'd0;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State, byte counter, latched request and load-assembly registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= 3'd0;
      op_r    <= 8'd0;
      base_r  <= 32'd0;
      sdata_r <= 32'd0;
      rd_r    <= 5'd0;
      wreg_r  <= 1'b0;
      asm_r   <= 32'd0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (state_s == ACCESS) begin
            op_r    <= aluop_i;
            base_r  <= mem_addr_i;
            sdata_r <= reg2_i;
            rd_r    <= rd_i;
            wreg_r  <= wreg_i;
            k_r     <= 3'd0;
            asm_r   <= 32'd0;
          end
        end
        ACCESS: begin
          k_r <= k_r + 3'd1;
          if (is_load_f(op_r)) begin
            case (k_r)
              3'd1:    asm_r[7:0]   <= ram_din_i;
              3'd2:    asm_r[15:8]  <= ram_din_i;
              3'd3:    asm_r[23:16] <= ram_din_i;
              3'd4:    asm_r[31:24] <= ram_din_i;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a cycle-level expectation queue built from the
// access rules and a reference byte memory, checked against the DUT every cycle.
module tb_mem_access;

  localparam logic [7:0] LB  = 8'h20;
  localparam logic [7:0] LH  = 8'h21;
  localparam logic [7:0] LW  = 8'h22;
  localparam logic [7:0] LBU = 8'h23;
  localparam logic [7:0] LHU = 8'h24;
  localparam logic [7:0] SB  = 8'h25;
  localparam logic [7:0] SH  = 8'h26;
  localparam logic [7:0] SW  = 8'h27;
  localparam logic [7:0] ADD = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic        preload;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, reg2, wdata_in;
  logic [4:0]  rd_in;
  logic        wreg_in;
  logic [4:0]  rd_out;
  logic        wreg_out;
  logic [31:0] wdata_out;
  logic        stall_req;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;

  logic [7:0]  ram [0:4095];
  logic [7:0]  ref_mem [0:4095];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  dout;
    logic [4:0]  rd;
    logic        wreg;
    logic [31:0] wdata;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  mem_access dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2),
    .wdata_i(wdata_in), .rd_i(rd_in), .wreg_i(wreg_in), .rd_o(rd_out), .wreg_o(wreg_out),
    .wdata_o(wdata_out), .stall_req_o(stall_req), .ram_addr_o(ram_addr), .ram_wr_o(ram_wr),
    .ram_dout_o(ram_dout), .ram_din_i(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h100:   return 8'h78;
      'h101:   return 8'h56;
      'h102:   return 8'h34;
      'h103:   return 8'h12;
      'h110:   return 8'h80;
      'h120:   return 8'h34;
      'h121:   return 8'hF2;
      'h201:   return 8'h11;
      default: return 8'h00;
    endcase
  endfunction

  // Byte RAM with one-cycle registered read, indexed by the low 12 address bits.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
    end else if (ram_wr) begin
      ram[ram_addr[11:0]] <= ram_dout;
    end
    ram_din <= ram[ram_addr[11:0]];
  end

  function automatic exp_t mk(input logic s, input logic w, input logic [31:0] a,
                              input logic [7:0] d, input logic [4:0] r, input logic we,
                              input logic [31:0] wd);
    exp_t e;
    e.stall = s; e.wr = w; e.addr = a; e.dout = d; e.rd = r; e.wreg = we; e.wdata = wd;
    return e;
  endfunction

  task automatic push(input string nm, input exp_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare every expected cycle against the DUT outputs, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (stall_req !== e.stall || ram_wr !== e.wr || ram_addr !== e.addr ||
          ram_dout !== e.dout || rd_out !== e.rd || wreg_out !== e.wreg || wdata_out !== e.wdata) begin
        errors++;
        $display("FAIL %s: got stall=%0b wr=%0b addr=%h dout=%h rd=%0d wreg=%0b wdata=%h, expected stall=%0b wr=%0b addr=%h dout=%h rd=%0d wreg=%0b wdata=%h",
                 nm, stall_req, ram_wr, ram_addr, ram_dout, rd_out, wreg_out, wdata_out,
                 e.stall, e.wr, e.addr, e.dout, e.rd, e.wreg, e.wdata);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic nop(input string nm, input logic [31:0] wd, input logic [4:0] r, input logic w);
    aluop = ADD; wdata_in = wd; rd_in = r; wreg_in = w;
    mem_addr = 32'h0000_0100; reg2 = 32'h5A5A_5A5A;
    if (rst) push(nm, mk(1'b0, 1'b0, 32'd0, 8'd0, 5'd0, 1'b0, 32'd0));
    else     push(nm, mk(1'b0, 1'b0, 32'd0, 8'd0, r, w, wd));
    step();
  endtask

  // One complete memory op, inputs held through the result cycle; returns the load value.
  task automatic do_mem(input string nm, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] r, input logic w,
                        output logic [31:0] res);
    int          n;
    bit          ld;
    logic [31:0] a;
    logic [7:0]  b;
    n  = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    ld = (op == LB || op == LH || op == LW || op == LBU || op == LHU);
    aluop = op; mem_addr = addr; reg2 = data; rd_in = r; wreg_in = w; wdata_in = 32'hDEAD_BEEF;
    push({nm, "_start"}, mk(1'b1, 1'b0, 32'd0, 8'd0, 5'd0, 1'b0, 32'd0));
    step();
    res = 32'd0;
    if (ld) begin
      for (int j = 0; j <= n; j++) begin
        a = addr + 32'(j);
        push({nm, "_acc"}, mk(1'b1, 1'b0, (j < n) ? a : 32'd0, 8'd0, 5'd0, 1'b0, 32'd0));
        step();
      end
      for (int j = 0; j < n; j++) begin
        a = addr + 32'(j);
        res = res | (32'(ref_mem[a[11:0]]) << (8 * j));
      end
      if (op == LB && res[7])  res = res | 32'hFFFF_FF00;
      if (op == LH && res[15]) res = res | 32'hFFFF_0000;
      push({nm, "_done"}, mk(1'b0, 1'b0, 32'd0, 8'd0, r, w, res));
      step();
    end else begin
      for (int j = 0; j < n; j++) begin
        a = addr + 32'(j);
        b = 8'((data >> (8 * j)) & 32'hFF);
        ref_mem[a[11:0]] = b;
        push({nm, "_wr"}, mk(1'b1, 1'b1, a, b, 5'd0, 1'b0, 32'd0));
        step();
      end
      push({nm, "_done"}, mk(1'b0, 1'b0, 32'd0, 8'd0, 5'd0, 1'b0, 32'd0));
      step();
    end
  endtask

  initial begin
    logic [31:0] res;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
    rst = 1'b1; preload = 1'b1;
    aluop = ADD; mem_addr = 32'd0; reg2 = 32'd0; wdata_in = 32'd0; rd_in = 5'd0; wreg_in = 1'b0;
    step();
    preload = 1'b0;
    nop("reset_outputs", 32'h0000_1234, 5'd5, 1'b1);
    rst = 1'b0;
    nop("add_pass", 32'h0000_1234, 5'd5, 1'b1);

    do_mem("lw100", LW, 32'h0000_0100, 32'd0, 5'd7, 1'b1, res);
    chk("lw100_val", res, 32'h1234_5678);
    nop("after_lw", 32'h0000_0042, 5'd8, 1'b1);

    do_mem("lb", LB, 32'h0000_0110, 32'd0, 5'd1, 1'b1, res);
    chk("lb_val", res, 32'hFFFF_FF80);
    do_mem("lbu", LBU, 32'h0000_0110, 32'd0, 5'd2, 1'b1, res);
    chk("lbu_val", res, 32'h0000_0080);
    do_mem("lh", LH, 32'h0000_0120, 32'd0, 5'd3, 1'b1, res);
    chk("lh_val", res, 32'hFFFF_F234);
    do_mem("lhu", LHU, 32'h0000_0120, 32'd0, 5'd4, 1'b0, res);
    chk("lhu_val", res, 32'h0000_F234);
    nop("after_loads", 32'hCAFE_0001, 5'd31, 1'b1);

    do_mem("sw_wrap", SW, 32'hFFFF_FFFE, 32'hAABB_CCDD, 5'd9, 1'b1, res);
    nop("after_sw", 32'h0000_0007, 5'd6, 1'b0);
    chk("ram_fffffffe", {24'd0, ram[12'hFFE]}, 32'h0000_00DD);
    chk("ram_ffffffff", {24'd0, ram[12'hFFF]}, 32'h0000_00CC);
    chk("ram_0", {24'd0, ram[12'h000]}, 32'h0000_00BB);
    chk("ram_1", {24'd0, ram[12'h001]}, 32'h0000_00AA);
    do_mem("lw_wrap", LW, 32'hFFFF_FFFE, 32'd0, 5'd10, 1'b1, res);
    chk("lw_wrap_val", res, 32'hAABB_CCDD);

    do_mem("sb103", SB, 32'h0000_0103, 32'h1234_56EE, 5'd11, 1'b1, res);
    do_mem("lw_mis", LW, 32'h0000_0101, 32'd0, 5'd12, 1'b1, res);
    chk("lw_mis_val", res, 32'h00EE_3456);
    nop("after_mis", 32'h0000_0099, 5'd13, 1'b1);

    // Store aborted by reset after its first byte.
    aluop = SH; mem_addr = 32'h0000_0200; reg2 = 32'h0000_5566; rd_in = 5'd3; wreg_in = 1'b1;
    push("sh_rst_start", mk(1'b1, 1'b0, 32'd0, 8'd0, 5'd0, 1'b0, 32'd0));
    step();
    ref_mem[12'h200] = 8'h66;
    push("sh_rst_byte0", mk(1'b1, 1'b1, 32'h0000_0200, 8'h66, 5'd0, 1'b0, 32'd0));
    step();
    rst = 1'b1;
    push("sh_rst_abort", mk(1'b0, 1'b0, 32'd0, 8'd0, 5'd0, 1'b0, 32'd0));
    step();
    rst = 1'b0;
    nop("after_rst", 32'h0000_0777, 5'd14, 1'b1);
    chk("ram_200_written", {24'd0, ram[12'h200]}, 32'h0000_0066);
    chk("ram_201_untouched", {24'd0, ram[12'h201]}, 32'h0000_0011);
    do_mem("lhu200", LHU, 32'h0000_0200, 32'd0, 5'd15, 1'b1, res);
    chk("lhu200_val", res, 32'h0000_1166);
    nop("final_nop", 32'h0000_0001, 5'd0, 1'b0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters (name, default, meaning): OP_LB 8'h20 load byte signed; OP_LH 8'h21 load half signed; OP_LW 8'h22 load word; OP_LBU 8'h23 load byte unsigned; OP_LHU 8'h24 load half unsigned; OP_SB 8'h25 store byte; OP_SH 8'h26 store half; OP_SW 8'h27 store word.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 aluop_i  in  8  operation from execute stage; values outside REQ-001 are non-memory ops.
REQ-005 mem_addr_i  in  32  effective byte address from execute stage.
REQ-006 reg2_i  in  32  store data.
REQ-007 wdata_i  in  32  execute result for non-memory ops.
REQ-008 rd_i  in  5 / wreg_i  in  1  destination register and write enable.
REQ-009 rd_o  out  5 / wreg_o  out  1 / wdata_o  out  32  writeback request.
REQ-010 stall_req_o  out  1  pipeline stall request; upstream stage inputs are held stable while high.
REQ-011 ram_addr_o  out  32 / ram_wr_o  out  1 / ram_dout_o  out  8  byte-wide RAM port.
REQ-012 ram_din_i  in  8  RAM read data; byte for the address presented in cycle N is valid in cycle N+1.

Function
REQ-013 FSM states IDLE, ACCESS, DONE; byte counter k, 3 bits; N = 1 (B/BU), 2 (H/HU), 4 (W).
REQ-014 IDLE, non-memory op: combinational pass-through rd_o=rd_i, wreg_o=wreg_i, wdata_o=wdata_i, stall_req_o=0, ram_wr_o=0; remain IDLE.
REQ-015 IDLE, memory op: stall_req_o=1 combinationally in the same cycle; latch op, address, store data, rd, wreg; k<=0; go to ACCESS; no RAM activity in this cycle.
REQ-016 ACCESS: stall_req_o=1, wreg_o=0, rd_o=0, wdata_o=0.
REQ-017 Store in ACCESS: ram_wr_o=1, ram_addr_o=base+k, ram_dout_o=byte k of store data (little-endian, byte 0 = bits 7:0); after k=N-1 go to DONE.
REQ-018 Load in ACCESS: ram_wr_o=0; for k<N present ram_addr_o=base+k; for k>=1 capture ram_din_i into byte k-1 of assembly register; after k=N go to DONE (N+1 ACCESS cycles).
REQ-019 Address arithmetic is 32-bit modulo 2^32; base+k wraps past 32'hFFFFFFFF to 0; misaligned addresses are legal and need no special handling.
REQ-020 DONE: stall_req_o=0, ram_wr_o=0, one cycle, then IDLE; DONE does not re-detect the still-present memory op.
REQ-021 DONE, load: rd_o=latched rd, wreg_o=latched wreg, wdata_o = sign-extended (LB, LH), zero-extended (LBU, LHU) or full word (LW).
REQ-022 DONE, store: wreg_o=0, rd_o=0, wdata_o=0.
REQ-023 Total stall cycles: load N+2, store N+1; result presented in the following (DONE) cycle.
REQ-024 ram_addr_o and ram_dout_o are 0 whenever there is no access in progress.

Reset
REQ-025 rst high at a clock edge: state<=IDLE, k<=0, latched registers<=0; outputs in the reset cycle: stall_req_o=0, ram_wr_o=0, ram_addr_o=0, ram_dout_o=0, rd_o=0, wreg_o=0, wdata_o=0.
REQ-026 rst asserted mid-ACCESS aborts the access; no further RAM write occurs after the reset edge; partially written bytes are not rolled back.

Verification
REQ-027 ADD result wdata_i=32'h1234, rd_i=5, wreg_i=1 in IDLE -> same-cycle rd_o=5, wreg_o=1, wdata_o=32'h1234, stall_req_o=0.
REQ-028 LW addr 32'h100, RAM 100..103 = 78,56,34,12 -> stall high 6 cycles, addresses 100..103 presented, 7th cycle wdata_o=32'h12345678, stall_req_o=0.
REQ-029 LB and LBU at a byte holding 8'h80 -> wdata_o=32'hFFFFFF80 and 32'h00000080 respectively; LH at bytes 34,F2 -> 32'hFFFFF234.
REQ-030 SW addr 32'hFFFFFFFE, data 32'hAABBCCDD -> writes DD@FFFFFFFE, CC@FFFFFFFF, BB@0, AA@1; stall high 5 cycles; DONE with wreg_o=0.
REQ-031 SH started, rst asserted after first byte written -> next cycle ram_wr_o=0, stall_req_o=0, state IDLE; second byte never written.
REQ-032 Memory op held on inputs through DONE -> exactly one access performed; next memory op starts only from IDLE.
